roi_dout_monitor: RTL and testbench
===================================

Name: roi_dout_monitor

Overview:
Static-region consumer of the DOUT_N-bit output bus driven by the dynamically reconfigured partition.
- Synchronizes the bus and qualifies it as stable.
- Commits and reports the stable value.
- Detects changes of the committed value, i.e. partial-reconfiguration events, and counts them.
- Drives a status LED that blinks only while a qualified value is present.

It sits in the static logic beside the partition, so its output is valid across reconfiguration.

Parameters:
DOUT_N, 3, width of monitored bus
STABLE_CYCLES, 16, consecutive equal synchronized samples required to commit (>=2)
CNT_W, 8, width of change counter
BLINK_DIV, 10000000, clk cycles per LED toggle while valid (>=2)

Ports:
clk  input  1  sole clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  DOUT_N  bus from dynamic partition; asynchronous or glitchy during reconfiguration
value  output  DOUT_N  last committed stable value
value_valid  output  1  high while in STABLE
change_pulse  output  1  one-cycle pulse when a newly committed value differs from the previous committed value
change_count  output  CNT_W  number of change_pulse events, saturating at all-ones
blinky  output  1  status LED

Behaviour:
- Reset: synchronous, active-high on clk; takes effect on the edge where rst=1, including mid-operation. Reset values:
  - s1, s2, candidate, stab_cnt, value: 0
  - value_valid, change_pulse, blinky: 0
  - change_count: 0
  - state: INIT
  - have_prev: 0
  - blink divider: 0
- Synchronizer: s1<=din, s2<=s1. Two-edge latency.
- Qualifier, evaluated each edge in priority order:
  - s2 != candidate:
    - candidate<=s2, stab_cnt<=0.
    - If state==STABLE: state<=SETTLING and value_valid<=0.
    - value is held.
  - Else if state!=STABLE and stab_cnt==STABLE_CYCLES-1: commit.
  - Else if state!=STABLE: stab_cnt<=stab_cnt+1.
  - Else (STABLE, equal): no change.
- Commit:
  - value<=candidate, value_valid<=1, state<=STABLE, stab_cnt<=0.
  - If have_prev && candidate!=value: change_pulse<=1 for exactly one cycle, and change_count increments unless already all-ones.
  - have_prev<=1.
  - The first commit after reset never pulses.
  - Recommitting the same value after a glitch never pulses.
- States:
  - INIT: no commit since reset.
  - SETTLING: qualifying after a disturbance.
  - STABLE.
  - Transitions: INIT/SETTLING -> STABLE on commit; STABLE -> SETTLING on mismatch. INIT is entered only by reset.
- Timing:
  - din constant from reset release, value X != 0 (X becomes visible on s2 at edge 2): candidate loads at edge 3, commit at edge 3+STABLE_CYCLES.
  - X==0: commit at edge STABLE_CYCLES.
  - A disturbance shorter than STABLE_CYCLES synchronized cycles never commits.
- change_pulse: deasserted on every edge except a commit edge that flags a change.
- Blink:
  - While value_valid: the divider counts 0..BLINK_DIV-1 and blinky toggles on each wrap, so the first toggle comes BLINK_DIV edges after value_valid rises.
  - While !value_valid: divider<=0 and blinky<=0.
- Widths: stab_cnt is wide enough for STABLE_CYCLES-1. The divider is wide enough for BLINK_DIV-1. No arithmetic overflow other than the defined saturation.

Test Plan:
All scenarios use STABLE_CYCLES=4, BLINK_DIV=8, DOUT_N=3, CNT_W=2 unless noted. Edges are counted from the first edge with rst=0.
- Reset then din=3'd5 held -> value_valid=1 and value=5 after edge 7; change_pulse never asserts; change_count=0.
- Reset then din=0 held -> value_valid=1, value=0 after edge 4; at valid+8 edges blinky=1, at valid+16 edges blinky=0.
- From STABLE value=5, din=3'd2 held -> value_valid falls 3 edges after the din change and value stays 5 while invalid. Commit to 2 occurs 4 edges after the fall, with a one-cycle change_pulse and change_count=1. blinky is 0 while invalid.
- From STABLE value=5, din=3'd7 for 2 cycles then back to 5 -> value_valid drops, recommits 5, no change_pulse, change_count unchanged.
- Alternate din between 1 and 6, each held 10 cycles, for 5 changes -> change_count saturates at 3 and change_pulse still fires on every change.
- Assert rst for 1 cycle while SETTLING with change_count=2 -> all outputs return to reset values on that edge. Requalification then restarts, and its first commit does not pulse.

Source files
------------

// File: rtl/roi_dout_monitor.sv
// Purpose : static-side monitor of the reconfigurable partition's output bus: synchronize,
//           qualify as stable, commit, count changes of the committed value, blink a status LED.
// Latency : 2 edges of synchronization, then STABLE_CYCLES equal samples before a commit.
// Backpressure: none; free-running observer, din is sampled every clk edge.
// Ports   : clk, rst (sync, active-high); din (async bus from the partition);
//           value/value_valid (committed value and its qualifier); change_pulse/change_count
//           (one pulse and a saturating count per change of committed value); blinky (LED).
module roi_dout_monitor #(
    parameter int DOUT_N        = 3,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8,
    parameter int BLINK_DIV     = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DOUT_N-1:0] din,
    output logic [DOUT_N-1:0] value,
    output logic              value_valid,
    output logic              change_pulse,
    output logic [CNT_W-1:0]  change_count,
    output logic              blinky
);

    localparam int SC_W  = $clog2(STABLE_CYCLES);
    localparam int DIV_W = $clog2(BLINK_DIV);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_SETTLING,
        ST_STABLE
    } state_t;

    state_t            state, state_d;
    logic [DOUT_N-1:0] s1, s2;
    logic [DOUT_N-1:0] candidate, candidate_d;
    logic [SC_W-1:0]   stab_cnt, stab_cnt_d;
    logic [DOUT_N-1:0] value_d;
    logic              value_valid_d;
    logic              change_pulse_d;
    logic [CNT_W-1:0]  change_count_d;
    logic              have_prev, have_prev_d;
    logic [DIV_W-1:0]  blink_div;

    // Qualifier / commit logic. INIT and SETTLING qualify identically; INIT only
    // records that nothing has been committed since reset.
    always_comb begin
        state_d        = state;
        candidate_d    = candidate;
        stab_cnt_d     = stab_cnt;
        value_d        = value;
        value_valid_d  = value_valid;
        change_pulse_d = 1'b0;
        change_count_d = change_count;
        have_prev_d    = have_prev;

        if (s2 != candidate) begin
            // Any disturbance restarts qualification; value is held for the consumer.
            candidate_d = s2;
            stab_cnt_d  = '0;
            if (state == ST_STABLE) begin
                state_d       = ST_SETTLING;
                value_valid_d = 1'b0;
            end
        end else if (state != ST_STABLE && stab_cnt == SC_LAST) begin
            value_d       = candidate;
            value_valid_d = 1'b1;
            state_d       = ST_STABLE;
            stab_cnt_d    = '0;
            have_prev_d   = 1'b1;
            // A recommit of the same value after a glitch is not a reconfiguration event.
            if (have_prev && candidate != value) begin
                change_pulse_d = 1'b1;
                if (change_count != {CNT_W{1'b1}}) begin
                    change_count_d = change_count + 1'b1;
                end
            end
        end else if (state != ST_STABLE) begin
            stab_cnt_d = stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_INIT;
            s1           <= '0;
            s2           <= '0;
            candidate    <= '0;
            stab_cnt     <= '0;
            value        <= '0;
            value_valid  <= 1'b0;
            change_pulse <= 1'b0;
            change_count <= '0;
            have_prev    <= 1'b0;
        end else begin
            state        <= state_d;
            s1           <= din;
            s2           <= s1;
            candidate    <= candidate_d;
            stab_cnt     <= stab_cnt_d;
            value        <= value_d;
            value_valid  <= value_valid_d;
            change_pulse <= change_pulse_d;
            change_count <= change_count_d;
            have_prev    <= have_prev_d;
        end
    end

    // LED divider runs only while a qualified value is present; the first toggle
    // lands BLINK_DIV edges after value_valid rises.
    always_ff @(posedge clk) begin
        if (rst || !value_valid) begin
            blink_div <= '0;
            blinky    <= 1'b0;
        end else if (blink_div == DIV_LAST) begin
            blink_div <= '0;
            blinky    <= ~blinky;
        end else begin
            blink_div <= blink_div + 1'b1;
        end
    end

endmodule

// File: tb/tb_roi_dout_monitor.sv
// Purpose : self-checking bench for roi_dout_monitor (STABLE_CYCLES=4, BLINK_DIV=8, CNT_W=2).
// Latency : scenario tasks check fixed edge numbers; a random phase checks every edge.
// Backpressure: n/a.
module tb_roi_dout_monitor;

    localparam int SC = 4;
    localparam int BD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] din = 3'd0;
    logic [2:0] value;
    logic       value_valid;
    logic       change_pulse;
    logic [1:0] change_count;
    logic       blinky;

    int n_checks = 0;
    int n_fail   = 0;

    roi_dout_monitor #(
        .DOUT_N(3), .STABLE_CYCLES(SC), .CNT_W(2), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .value(value), .value_valid(value_valid),
        .change_pulse(change_pulse), .change_count(change_count), .blinky(blinky)
    );

    always #5 clk = ~clk;

    // Reference model, expressed as run lengths rather than a state machine:
    // the committed value is valid once the synchronized bus has matched its
    // previous sample on SC consecutive edges since the last disturbance, and a
    // commit happens exactly on the SC-th such edge.
    logic [2:0] m_s1, m_s2, m_prevx, m_val;
    int         m_run, m_k, m_cnt;
    logic       m_valid, m_pulse, m_blinky, m_have_prev;

    task automatic model_edge();
        logic [2:0] x;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_prevx = 0; m_val = 0;
            m_run = 0; m_k = 0; m_cnt = 0;
            m_valid = 0; m_pulse = 0; m_blinky = 0; m_have_prev = 0;
        end else begin
            x    = m_s2;
            m_s2 = m_s1;
            m_s1 = din;
            // edges spent with a valid value so far; LED phase = (k / BD) mod 2
            m_k      = m_valid ? m_k + 1 : 0;
            m_blinky = ((m_k / BD) % 2) == 1;
            m_run    = (x != m_prevx) ? 0 : m_run + 1;
            m_prevx  = x;
            m_pulse  = 1'b0;
            if (m_run == SC) begin
                if (m_have_prev && x != m_val) begin
                    m_pulse = 1'b1;
                    if (m_cnt < 3) m_cnt = m_cnt + 1;
                end
                m_val       = x;
                m_have_prev = 1'b1;
            end
            m_valid = (m_run >= SC);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] d);
        din = d;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd6);
        n_checks++;
        if (value !== 3'd0 || value_valid !== 1'b0 || change_pulse !== 1'b0 ||
            change_count !== 2'd0 || blinky !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: value=%0d valid=%0b pulse=%0b cnt=%0d blinky=%0b, required all 0",
                     value, value_valid, change_pulse, change_count, blinky);
        end
    endtask

    task automatic test_commit_nonzero();
        int pulses = 0;
        do_reset(3'd5);
        for (int e = 1; e <= 7; e++) begin
            step();
            if (change_pulse) pulses++;
            if (e == 6) begin
                n_checks++;
                if (value_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL commit5_early: valid=%0b at edge 6, required 0", value_valid);
                end
            end
        end
        n_checks++;
        if (value_valid !== 1'b1 || value !== 3'd5) begin
            n_fail++;
            $display("FAIL commit5: valid=%0b value=%0d at edge 7, required 1/5", value_valid, value);
        end
        n_checks++;
        if (pulses != 0 || change_count !== 2'd0) begin
            n_fail++;
            $display("FAIL first_commit_pulse: pulses=%0d cnt=%0d, required 0/0", pulses, change_count);
        end
    endtask

    task automatic test_zero_blink();
        do_reset(3'd0);
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 3 || e == 4) begin
                n_checks++;
                if (value_valid !== (e == 4) || value !== 3'd0) begin
                    n_fail++;
                    $display("FAIL commit0: edge %0d valid=%0b value=%0d, required %0b/0",
                             e, value_valid, value, e == 4);
                end
            end
            if (e == 11 || e == 12 || e == 19 || e == 20) begin
                n_checks++;
                if (blinky !== (e == 12 || e == 19)) begin
                    n_fail++;
                    $display("FAIL blink: edge %0d blinky=%0b, required %0b", e, blinky, e == 12 || e == 19);
                end
            end
        end
    endtask

    task automatic test_change();
        do_reset(3'd5);
        repeat (10) step();
        din = 3'd2;
        for (int e = 11; e <= 18; e++) begin
            step();
            if (e >= 13 && e <= 16) begin
                n_checks++;
                if (value_valid !== 1'b0 || value !== 3'd5 || blinky !== 1'b0) begin
                    n_fail++;
                    $display("FAIL change_invalid: edge %0d valid=%0b value=%0d blinky=%0b, required 0/5/0",
                             e, value_valid, value, blinky);
                end
            end
            if (e == 12 || e == 17 || e == 18) begin
                n_checks++;
                if (value_valid !== 1'b1 || change_pulse !== (e == 17) ||
                    value !== (e == 12 ? 3'd5 : 3'd2) || change_count !== (e == 12 ? 2'd0 : 2'd1)) begin
                    n_fail++;
                    $display("FAIL change_commit: edge %0d valid=%0b pulse=%0b value=%0d cnt=%0d",
                             e, value_valid, change_pulse, value, change_count);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        do_reset(3'd5);
        repeat (10) step();
        din = 3'd7;
        step();
        step();
        din = 3'd5;
        for (int e = 13; e <= 22; e++) begin
            step();
            if (change_pulse) pulses++;
            if (e == 13 || e == 18 || e == 19) begin
                n_checks++;
                if (value_valid !== (e == 19) || value !== 3'd5) begin
                    n_fail++;
                    $display("FAIL glitch: edge %0d valid=%0b value=%0d, required %0b/5",
                             e, value_valid, value, e == 19);
                end
            end
        end
        n_checks++;
        if (pulses != 0 || change_count !== 2'd0) begin
            n_fail++;
            $display("FAIL glitch_pulse: pulses=%0d cnt=%0d, required 0/0", pulses, change_count);
        end
    endtask

    task automatic test_saturate();
        do_reset(3'd1);
        repeat (10) step();
        for (int i = 1; i <= 5; i++) begin
            int pulses = 0;
            din = (i % 2) ? 3'd6 : 3'd1;
            repeat (10) begin
                step();
                if (change_pulse) pulses++;
            end
            n_checks++;
            if (pulses != 1 || int'(change_count) != ((i < 3) ? i : 3)) begin
                n_fail++;
                $display("FAIL saturate: change %0d pulses=%0d cnt=%0d, required 1/%0d",
                         i, pulses, change_count, (i < 3) ? i : 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset(3'd1);
        repeat (10) step();
        din = 3'd2;
        repeat (10) step();
        din = 3'd1;
        repeat (10) step();
        din = 3'd2;
        repeat (4) step();
        n_checks++;
        if (value_valid !== 1'b0 || change_count !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%0b cnt=%0d, required 0/2", value_valid, change_count);
        end
        do_reset(3'd2);
        n_checks++;
        if (value !== 3'd0 || value_valid !== 1'b0 || change_pulse !== 1'b0 ||
            change_count !== 2'd0 || blinky !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: value=%0d valid=%0b pulse=%0b cnt=%0d blinky=%0b, required all 0",
                     value, value_valid, change_pulse, change_count, blinky);
        end
        for (int e = 1; e <= 7; e++) begin
            step();
            if (change_pulse) pulses++;
        end
        n_checks++;
        if (value_valid !== 1'b1 || value !== 3'd2 || pulses != 0 || change_count !== 2'd0) begin
            n_fail++;
            $display("FAIL requalify: valid=%0b value=%0d pulses=%0d cnt=%0d, required 1/2/0/0",
                     value_valid, value, pulses, change_count);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        do_reset(3'd0);
        while (cyc < 3000) begin
            int hold;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                hold = 1;
            end else begin
                rst = 1'b0;
                din = 3'($urandom_range(0, 7));
                hold = $urandom_range(1, 12);
            end
            repeat (hold) begin
                step();
                cyc++;
                n_checks++;
                if (value !== m_val || value_valid !== m_valid || change_pulse !== m_pulse ||
                    int'(change_count) != m_cnt || blinky !== m_blinky) begin
                    n_fail++;
                    $display("FAIL random cyc %0d: got v=%0d vv=%0b p=%0b c=%0d b=%0b exp v=%0d vv=%0b p=%0b c=%0d b=%0b",
                             cyc, value, value_valid, change_pulse, change_count, blinky,
                             m_val, m_valid, m_pulse, m_cnt, m_blinky);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_nonzero();
        test_zero_blink();
        test_change();
        test_glitch();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
